movegen_square_seq: RTL

// - Square sequencer for streamed board positions: one square per valid beat, starting at the sop beat.
// - Tags each beat with its absolute and side-relative square index, rank and file.
// - Flags the last square and detects framing errors (truncated or orphan beats).
// - Sits at the head of movegen, in front of the per-square generators.
// - Generalises the 8x8 counter: arbitrary FILES x RANKS, rank mirroring, framing checks, frame count.

---
 rtl/movegen_square_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/movegen_square_seq.sv
// Square sequencer for streamed board positions. Tags each accepted beat with its
// absolute and side-relative square, rank and file, and flags framing errors.
module movegen_square_seq #(
  parameter  int FILES  = 8,
  parameter  int RANKS  = 8,
  parameter  int SQ_W   = $clog2(FILES*RANKS),
  parameter  int CNT_W  = 16,
  localparam int FILE_W = $clog2(FILES),
  localparam int RANK_W = $clog2(RANKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_pos_valid,
  input  logic              in_pos_sop,
  input  logic              in_flip,
  output logic              out_sq_valid,
  output logic [SQ_W-1:0]   out_sq,
  output logic [SQ_W-1:0]   out_sq_rel,
  output logic [RANK_W-1:0] out_rank,
  output logic [FILE_W-1:0] out_file,
  output logic              out_last,
  output logic              out_err_short,
  output logic              out_err_orphan,
  output logic [CNT_W-1:0]  out_pos_count
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  localparam logic [FILE_W-1:0] FILE_MAX = FILE_W'(FILES - 1);
  localparam logic [RANK_W-1:0] RANK_MAX = RANK_W'(RANKS - 1);

  state_e            state_q, state_d;
  logic [FILE_W-1:0] file_q, file_d, cur_file;
  logic [RANK_W-1:0] rank_q, rank_d, cur_rank, rel_rank;
  logic              flip_q, flip_d, flip_sel;
  logic              err_short_q, err_short_d;
  logic              err_orphan_q, err_orphan_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              start, accept, last;

  // Coordinates of the beat on the inputs this cycle; no added latency.
  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    start    = in_pos_valid & in_pos_sop;
    cur_file = file_q;
    cur_rank = rank_q;
    if (start) begin
      cur_file = '0;
      cur_rank = '0;
    end else if (in_pos_valid) begin
      if (file_q == FILE_MAX) begin
        cur_file = '0;
        cur_rank = rank_q + RANK_W'(1);
      end else begin
        cur_file = file_q + FILE_W'(1);
      end
    end
    accept   = in_pos_valid & (in_pos_sop | (state_q == ACTIVE)) & ~rst;
    flip_sel = start ? in_flip : flip_q;
    rel_rank = flip_sel ? (RANK_MAX - cur_rank) : cur_rank;
    last     = accept & (cur_file == FILE_MAX) & (cur_rank == RANK_MAX);
  end

  always_comb begin
    state_d      = state_q;
    file_d       = file_q;
    rank_d       = rank_q;
    flip_d       = flip_q;
    count_d      = count_q;
    err_short_d  = accept & in_pos_sop & (state_q == ACTIVE);
    err_orphan_d = in_pos_valid & ~in_pos_sop & (state_q == IDLE);
    if (accept) begin
      file_d  = cur_file;
      rank_d  = cur_rank;
      flip_d  = flip_sel;
      state_d = last ? IDLE : ACTIVE;
      if (last) count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, so it sits inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      file_q       <= '0;
      rank_q       <= '0;
      flip_q       <= 1'b0;
      err_short_q  <= 1'b0;
      err_orphan_q <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      file_q       <= file_d;
      rank_q       <= rank_d;
      flip_q       <= flip_d;
      err_short_q  <= err_short_d;
      err_orphan_q <= err_orphan_d;
      count_q      <= count_d;
    end
  end

  assign out_sq_valid   = accept;
  assign out_sq         = SQ_W'(cur_rank) * SQ_W'(FILES) + SQ_W'(cur_file);
  assign out_sq_rel     = SQ_W'(rel_rank) * SQ_W'(FILES) + SQ_W'(cur_file);
  assign out_rank       = cur_rank;
  assign out_file       = cur_file;
  assign out_last       = last;
  assign out_err_short  = err_short_q;
  assign out_err_orphan = err_orphan_q;
  assign out_pos_count  = count_q;

endmodule
